// File: rtl/daddr_split.sv
// Data-address generator: EA = base + offset, big-endian lane enables, store-data rotation.
// Define DADDR_SPLIT_EN to issue lane-group-crossing accesses as two beats instead of erroring.
module daddr_split #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic            SYSCLK,
  input  logic            RESET_D1_R,
  input  logic            CLMI_RHOLD,
  input  logic            REQ_E_P,
  output logic            REQ_RDY,
  input  logic            WRITE_E_P,
  input  logic [1:0]      SIZE_E_P,
  input  logic [AW-1:0]   REGA_E_R,
  input  logic [AW-1:0]   REGBI_E_R,
  input  logic [DW-1:0]   REGBR_E_R,
  output logic            DREQ_M_R,
  output logic            DWRITE_M_R,
  output logic [AW-1:0]   DADDR_M_R,
  output logic [DW/8-1:0] DBYEN_M_R,
  output logic [DW-1:0]   DWDATA_M_R,
  output logic            DLAST_M_R,
  output logic            DADALERR_M_R
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned L  = $clog2(NB);

`ifdef DADDR_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StBeat2} state_e;

  state_e          state_q, state_d;
  logic            dreq_q, dreq_d;
  logic            dwrite_q, dwrite_d;
  logic [AW-1:0]   daddr_q, daddr_d;
  logic [NB-1:0]   dbyen_q, dbyen_d;
  logic [DW-1:0]   dwdata_q, dwdata_d;
  logic            dlast_q, dlast_d;
  logic            derr_q, derr_d;
  logic [AW-1:0]   addr2_q, addr2_d;
  logic [NB-1:0]   byen2_q, byen2_d;

  logic [AW-1:0]   ea;
  logic [AW-L-1:0] grp_next;
  logic [AW-1:0]   ea_next_grp;
  logic [L-1:0]    off;
  logic [31:0]     off_n;
  logic [31:0]     len;
  logic            size_err;
  logic            misaligned;
  logic            crossing;
  logic            acc_err;
  logic            acc_split;
  logic [2*NB-1:0] lane_ext;
  logic [NB-1:0]   byen1;
  logic [NB-1:0]   byen2;
  logic [DW-1:0]   data_lj;
  logic [2*DW-1:0] data_dbl;
  logic [DW-1:0]   data_rot;
  logic            ready;
  logic            accept;

  assign ea          = REGA_E_R + REGBI_E_R;
  assign off         = ea[L-1:0];
  assign grp_next    = ea[AW-1:L] + (AW-L)'(1);
  assign ea_next_grp = {grp_next, {L{1'b0}}};

  always_comb begin
    off_n      = 32'(off);
    len        = 32'd1 << SIZE_E_P;
    size_err   = (DW == 32) && (SIZE_E_P == 2'd3);
    misaligned = (off_n & (len - 32'd1)) != 32'd0;
    crossing   = (off_n + len) > NB;
    acc_err    = size_err | (misaligned & ~SplitEn);
    acc_split  = crossing & SplitEn & ~acc_err;
  end

  // Lanes are numbered over two consecutive lane groups; the second group feeds beat 2.
  always_comb begin
    lane_ext = '0;
    byen1    = '0;
    byen2    = '0;
    for (int unsigned j = 0; j < 2 * NB; j++) begin
      lane_ext[j] = (j >= off_n) && (j < off_n + len);
    end
    for (int unsigned i = 0; i < NB; i++) begin
      byen1[NB-1-i] = lane_ext[i];
      byen2[NB-1-i] = lane_ext[NB+i];
    end
  end

  // Left-justify the low len bytes, then rotate right by off bytes.
  always_comb begin
    data_lj  = size_err ? '0 : (REGBR_E_R << ((NB - len) * 8));
    data_dbl = {data_lj, data_lj} >> (off_n * 8);
    data_rot = WRITE_E_P ? data_dbl[DW-1:0] : '0;
  end

  assign ready   = !CLMI_RHOLD && (state_q == StIdle) && !RESET_D1_R;
  assign accept  = REQ_E_P && ready;
  assign REQ_RDY = ready;

  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwrite_d = dwrite_q;
    daddr_d  = daddr_q;
    dbyen_d  = dbyen_q;
    dwdata_d = dwdata_q;
    dlast_d  = dlast_q;
    derr_d   = derr_q;
    addr2_d  = addr2_q;
    byen2_d  = byen2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dreq_d   = ~acc_err;
          dwrite_d = WRITE_E_P;
          daddr_d  = ea;
          dbyen_d  = acc_err ? '0 : byen1;
          dwdata_d = data_rot;
          dlast_d  = acc_err | ~acc_split;
          derr_d   = acc_err;
          addr2_d  = ea_next_grp;
          byen2_d  = byen2;
          if (acc_split) begin
            state_d = StBeat2;
          end
        end else begin
          dreq_d = 1'b0;
          derr_d = 1'b0;
        end
      end
      StBeat2: begin
        dreq_d  = 1'b1;
        daddr_d = addr2_q;
        dbyen_d = byen2_q;
        dlast_d = 1'b1;
        derr_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET_D1_R) begin
      state_q  <= StIdle;
      dreq_q   <= 1'b0;
      dwrite_q <= 1'b0;
      daddr_q  <= '0;
      dbyen_q  <= '0;
      dwdata_q <= '0;
      dlast_q  <= 1'b0;
      derr_q   <= 1'b0;
      addr2_q  <= '0;
      byen2_q  <= '0;
    end else if (!CLMI_RHOLD) begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwrite_q <= dwrite_d;
      daddr_q  <= daddr_d;
      dbyen_q  <= dbyen_d;
      dwdata_q <= dwdata_d;
      dlast_q  <= dlast_d;
      derr_q   <= derr_d;
      addr2_q  <= addr2_d;
      byen2_q  <= byen2_d;
    end
  end

  assign DREQ_M_R     = dreq_q;
  assign DWRITE_M_R   = dwrite_q;
  assign DADDR_M_R    = daddr_q;
  assign DBYEN_M_R    = dbyen_q;
  assign DWDATA_M_R   = dwdata_q;
  assign DLAST_M_R    = dlast_q;
  assign DADALERR_M_R = derr_q;

endmodule

// File: tb/tb_daddr_split.sv
// Bench for daddr_split: 32- and 64-bit instances share stimulus, checked against a byte-level
// model of each access. Honours DADDR_SPLIT_EN the same way the design does.
module tb_daddr_split;

`ifdef DADDR_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    bit          err;
    bit          split;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [7:0]  byen1;
    logic [7:0]  byen2;
    logic [63:0] wdata;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic        wr;
    logic        last;
    logic        err;
    logic [31:0] addr;
    logic [7:0]  byen;
    logic [63:0] wdata;
    bit          dk;
  } out_t;

  logic        clk = 1'b0;
  logic        rst, hold, req, wr;
  logic [1:0]  size;
  logic [31:0] rega, regb;
  logic [63:0] data;

  logic        r32, q32_req, q32_wr, q32_last, q32_err;
  logic [31:0] q32_addr, q32_wdata;
  logic [3:0]  q32_byen;
  logic        r64, q64_req, q64_wr, q64_last, q64_err;
  logic [31:0] q64_addr;
  logic [63:0] q64_wdata;
  logic [7:0]  q64_byen;

  int   nvec = 0;
  int   nerr = 0;
  out_t p[2];

  always #5 clk = ~clk;

  daddr_split #(.DW(32), .AW(32)) u_dut32 (
    .SYSCLK(clk), .RESET_D1_R(rst), .CLMI_RHOLD(hold), .REQ_E_P(req), .REQ_RDY(r32),
    .WRITE_E_P(wr), .SIZE_E_P(size), .REGA_E_R(rega), .REGBI_E_R(regb),
    .REGBR_E_R(data[31:0]), .DREQ_M_R(q32_req), .DWRITE_M_R(q32_wr), .DADDR_M_R(q32_addr),
    .DBYEN_M_R(q32_byen), .DWDATA_M_R(q32_wdata), .DLAST_M_R(q32_last),
    .DADALERR_M_R(q32_err)
  );

  daddr_split #(.DW(64), .AW(32)) u_dut64 (
    .SYSCLK(clk), .RESET_D1_R(rst), .CLMI_RHOLD(hold), .REQ_E_P(req), .REQ_RDY(r64),
    .WRITE_E_P(wr), .SIZE_E_P(size), .REGA_E_R(rega), .REGBI_E_R(regb),
    .REGBR_E_R(data), .DREQ_M_R(q64_req), .DWRITE_M_R(q64_wr), .DADDR_M_R(q64_addr),
    .DBYEN_M_R(q64_byen), .DWDATA_M_R(q64_wdata), .DLAST_M_R(q64_last),
    .DADALERR_M_R(q64_err)
  );

  // Walks the access byte by byte: byte k lives at address EA+k, lane (off+k) mod nb.
  function automatic exp_t model(int nb, bit w, int sz, logic [31:0] a_, logic [31:0] b_,
                                 logic [63:0] d_);
    exp_t        e;
    logic [31:0] ea;
    int          off, n, lane;
    e = '{default: 0};
    ea = a_ + b_;
    n = 1 << sz;
    off = int'(ea[2:0]) % nb;
    e.addr1 = ea;
    e.addr2 = ea - 32'(off) + 32'(nb);
    e.err = (n > nb) || (!SPLIT && (ea % 32'(n) != 0));
    e.split = SPLIT && !e.err && (off + n > nb);
    if (!e.err) begin
      for (int k = 0; k < n; k++) begin
        lane = off + k;
        if (lane < nb) e.byen1[nb-1-lane] = 1'b1;
        else           e.byen2[2*nb-1-lane] = 1'b1;
        if (w) e.wdata[8*(nb-1-(lane%nb)) +: 8] = d_[8*(n-1-k) +: 8];
      end
    end
    return e;
  endfunction

  function automatic out_t beat(exp_t e, int k, bit w);
    out_t x;
    x = '{default: 0};
    x.wr = w;
    x.dk = 1'b1;
    if (e.err) begin
      x.err = 1'b1; x.last = 1'b1; x.addr = e.addr1; x.dk = 1'b0;
    end else if (k == 1) begin
      x.req = 1'b1; x.last = !e.split; x.addr = e.addr1; x.byen = e.byen1; x.wdata = e.wdata;
    end else begin
      x.req = 1'b1; x.last = 1'b1; x.addr = e.addr2; x.byen = e.byen2; x.wdata = e.wdata;
    end
    return x;
  endfunction

  function automatic out_t idle(out_t x);
    out_t y;
    y = x;
    y.req = 1'b0;
    y.err = 1'b0;
    return y;
  endfunction

  function automatic out_t obs(int i);
    out_t o;
    o.dk = 1'b1;
    if (i == 0) begin
      o.rdy = r32; o.req = q32_req; o.wr = q32_wr; o.last = q32_last; o.err = q32_err;
      o.addr = q32_addr; o.byen = {4'b0, q32_byen}; o.wdata = {32'b0, q32_wdata};
    end else begin
      o.rdy = r64; o.req = q64_req; o.wr = q64_wr; o.last = q64_last; o.err = q64_err;
      o.addr = q64_addr; o.byen = q64_byen; o.wdata = q64_wdata;
    end
    return o;
  endfunction

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic cmp(string tag, int i, out_t e, logic erdy);
    out_t  o;
    string t;
    o = obs(i);
    t = $sformatf("%s/dw%0d", tag, (i == 0) ? 32 : 64);
    chk({t, ".rdy"}, 64'(o.rdy), 64'(erdy));
    chk({t, ".req"}, 64'(o.req), 64'(e.req));
    chk({t, ".err"}, 64'(o.err), 64'(e.err));
    chk({t, ".last"}, 64'(o.last), 64'(e.last));
    chk({t, ".addr"}, 64'(o.addr), 64'(e.addr));
    chk({t, ".byen"}, 64'(o.byen), 64'(e.byen));
    if (e.dk) begin
      chk({t, ".wr"}, 64'(o.wr), 64'(e.wr));
      chk({t, ".wdata"}, o.wdata, e.wdata);
    end
  endtask

  // mode 0: plain, 1: three hold cycles after beat 1, 2: reset after beat 1.
  task automatic access(string tag, bit w, int sz, logic [31:0] a_, logic [31:0] b_,
                        logic [63:0] d_, int mode);
    exp_t e[2];
    e[0] = model(4, w, sz, a_, b_, d_);
    e[1] = model(8, w, sz, a_, b_, d_);
    wr = w; size = 2'(sz); rega = a_; regb = b_; data = d_; req = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) cmp({tag, ".pre"}, i, p[i], 1'b1);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p[i] = beat(e[i], 1, w);
      cmp({tag, ".b1"}, i, p[i], !e[i].split);
    end
    if (mode == 2) begin
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        p[i] = '{default: 0};
        p[i].dk = 1'b1;
        cmp({tag, ".rst"}, i, p[i], 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) cmp({tag, ".postrst"}, i, p[i], 1'b1);
    end else begin
      if (mode == 1) begin
        hold = 1'b1;
        repeat (3) begin
          @(negedge clk);
          for (int i = 0; i < 2; i++) cmp({tag, ".hold"}, i, p[i], 1'b0);
        end
        hold = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        p[i] = e[i].split ? beat(e[i], 2, w) : idle(p[i]);
        cmp({tag, ".b2"}, i, p[i], 1'b1);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        p[i] = idle(p[i]);
        cmp({tag, ".idle"}, i, p[i], 1'b1);
      end
    end
  endtask

  initial begin
    int  sz, m;
    bit  w;
    logic [31:0] a_, b_;
    logic [63:0] d_;
    rst = 1'b1; hold = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0;
    rega = '0; regb = '0; data = '0;
    for (int i = 0; i < 2; i++) begin
      p[i] = '{default: 0};
      p[i].dk = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) cmp("reset", i, p[i], 1'b0);
    rst = 1'b0;

    access("word_st", 1'b1, 2, 32'h1000, 32'h4, 64'h11223344, 0);
    access("half_st", 1'b1, 1, 32'h1000, 32'h3, 64'hABCD, 0);
    access("wrap", 1'b0, 2, 32'hFFFF_FFF0, 32'hE, 64'h0, 0);
    access("dword", 1'b1, 3, 32'h2000, 32'h4, 64'h0011_2233_4455_6677, 0);
    access("hold", 1'b1, 1, 32'h1000, 32'h3, 64'hABCD, 1);
    access("rst", 1'b1, 1, 32'h1000, 32'h3, 64'hABCD, 2);
    access("byte_ld", 1'b0, 0, 32'h3000, 32'h7, 64'h55, 0);

    for (int n = 0; n < 200; n++) begin
      sz = int'($urandom_range(3, 0));
      w  = 1'($urandom_range(1, 0));
      a_ = $urandom;
      if ($urandom_range(3, 0) == 0) a_ = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      b_ = 32'($urandom_range(15, 0));
      d_ = {$urandom, $urandom};
      m  = int'($urandom_range(7, 0));
      access("rand", w, sz, a_, b_, d_, (m == 0) ? 1 : (m == 1) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/daddr_split.md
# daddr_split

Parametrised data-address generator with misaligned-access splitting, sitting between the E-stage register file read and the memory-stage data bus interface. It computes the effective address as base plus offset, derives big-endian byte enables for `DW`-wide data lanes, and rotates store data into its lanes. Each access goes out as one registered bus beat, or as two beats when a misaligned access crosses a lane-group boundary and splitting is compiled in.

## Interface

**Parameters**
- `DW`, default 32: data bus width; legal values are 32 and 64. `NB = DW/8` lanes, `L = log2(NB)`.
- `AW`, default 32: address width.

**Ports**
- `SYSCLK`  in  1  sole clock; all state updates on its rising edge.
- `RESET_D1_R`  in  1  reset, synchronous, active-high.
- `CLMI_RHOLD`  in  1  pipeline hold; freezes all state and outputs.
- `REQ_E_P`  in  1  new access request.
- `REQ_RDY`  out  1  request accepted this cycle when high together with `REQ_E_P`.
- `WRITE_E_P`  in  1  1 = store, 0 = load.
- `SIZE_E_P`  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when `DW`=64).
- `REGA_E_R`  in  AW  base operand.
- `REGBI_E_R`  in  AW  offset operand.
- `REGBR_E_R`  in  DW  store data, right-justified.
- `DREQ_M_R`  out  1  bus beat valid.
- `DWRITE_M_R`  out  1  beat is a store.
- `DADDR_M_R`  out  AW  beat address.
- `DBYEN_M_R`  out  NB  lane enables; the MSB lane is address offset 0.
- `DWDATA_M_R`  out  DW  lane-placed store data.
- `DLAST_M_R`  out  1  final beat of the access.
- `DADALERR_M_R`  out  1  alignment or size error; no bus beat is issued.

## Operation

- Accept condition: `REQ_E_P & REQ_RDY`.
- `REQ_RDY` is `!CLMI_RHOLD & (state == IDLE) & !RESET_D1_R`.
- Effective address: `EA = (REGA_E_R + REGBI_E_R) mod 2^AW`; the carry out is discarded.
- Offset and length: `off = EA[L-1:0]`, `N = 1 << SIZE_E_P` bytes.
- Lane enables: lane i is enabled iff `off <= i < off+N`, counting lane 0 as the MSB byte.
- Crossing access: `off + N > NB`.
- Illegal size: `SIZE_E_P` = 3 with `DW` = 32 produces an error beat.
- Store data placement: the low N bytes of `REGBR_E_R` are left-justified into a DW word, zero-filled, then rotated right by `off` bytes. The result drives `DWDATA_M_R` on every beat of the access. For loads, `DWDATA_M_R` is 0.
- Error beat (one cycle): `DADALERR_M_R` = 1, `DREQ_M_R` = 0, `DBYEN_M_R` = 0, `DLAST_M_R` = 1, and `DADDR_M_R` = `EA`.
- State machine has two states:
  - IDLE: on accept, load beat 1 into the output registers. If the access splits, go to BEAT2; otherwise stay in IDLE.
  - BEAT2: on the next non-held cycle, issue beat 2 and return to IDLE.
- When nothing is accepted in IDLE, the next cycle drives `DREQ_M_R` = 0 and `DADALERR_M_R` = 0. The other outputs hold their previous values.

## Timing

- Latency: request accepted in cycle T, beat 1 appears on the outputs in cycle T+1.
- Split access: beat 2 appears in T+2, and `REQ_RDY` is 0 during T+1.
- Non-split accesses can be accepted back to back, one per cycle.
- `CLMI_RHOLD` = 1: all registers and the state hold, outputs are stable, and `REQ_RDY` = 0. A pending beat 2 waits until the hold drops.
- Reset (`RESET_D1_R` = 1 at a clock edge): state becomes IDLE and every output register clears to 0, including `DADDR_M_R`, `DBYEN_M_R` and `DWDATA_M_R`. Any pending beat 2 is discarded.
- Reset takes priority over `CLMI_RHOLD`.

## Configuration

`DADDR_SPLIT_EN`

**Defined:**
- Misaligned accesses that do not cross are issued as a single beat with no error.
- Crossing accesses are issued as two beats:
  - Beat 1: address `EA`, lanes `off .. NB-1`, `DLAST_M_R` = 0.
  - Beat 2: address `((EA >> L) + 1) << L` mod 2^AW, lanes `0 .. off+N-NB-1`, `DLAST_M_R` = 1.

**Undefined:**
- Any access with `off mod N != 0` produces an error beat.
- The BEAT2 state is unreachable and may be optimised out.

**Both builds:**
- The illegal-size check behaves identically.

## Test plan

1. `DW`=32, aligned word store:
   - Stimulus: `REGA_E_R` = 0x1000, `REGBI_E_R` = 0x4, `REGBR_E_R` = 0x11223344.
   - Required at T+1: `DADDR_M_R` = 0x1004, `DBYEN_M_R` = 1111, `DWDATA_M_R` = 0x11223344, `DLAST_M_R` = 1.
2. `DW`=32 with split, half store at EA 0x1003, `REGBR_E_R` = 0x0000ABCD:
   - Beat 1: `DADDR_M_R` = 0x1003, `DBYEN_M_R` = 0001, `DWDATA_M_R` = 0xCD0000AB.
   - Beat 2: `DADDR_M_R` = 0x1004, `DBYEN_M_R` = 1000, `DWDATA_M_R` = 0xCD0000AB, `DLAST_M_R` = 1.
   - `REQ_RDY` is 0 in the middle cycle.
3. Same stimulus as scenario 2 without the macro:
   - Single cycle with `DADALERR_M_R` = 1, `DREQ_M_R` = 0, `DBYEN_M_R` = 0000.
4. Address wrap, word access at EA 0xFFFFFFFE with split:
   - Beat 1: `DBYEN_M_R` = 0011, `DADDR_M_R` = 0xFFFFFFFE.
   - Beat 2: `DADDR_M_R` = 0x00000000, `DBYEN_M_R` = 1100.
5. `DW`=64, dword store at EA 0x2004, data 0x0011223344556677:
   - `DWDATA_M_R` = 0x4455667700112233.
   - Beat 1: `DBYEN_M_R` = 0x0F. Beat 2: address 0x2008, `DBYEN_M_R` = 0xF0.
   - With `SIZE_E_P` = 3 and `DW` = 32, the result is an error beat.
6. Hold and reset during a split:
   - Assert `CLMI_RHOLD` for 3 cycles after beat 1: outputs stay frozen, then beat 2 issues.
   - Separately, assert `RESET_D1_R` after beat 1: the next cycle shows all outputs 0, state IDLE, and no beat 2.
